sync_fifo_lvl: RTL and testbench

Parametrised synchronous FIFO with level reporting. It is the next generation of the single-clock FIFO used in the UART-to-AXI bridge between the UART byte path and the AXI command/response paths. It adds an occupancy count, threshold flags, sticky overflow/underflow error flags and a synchronous flush. It also defines a safe simultaneous read/write when empty.

---
 rtl/sync_fifo_lvl_if.sv | 34 +++
 rtl/sync_fifo_lvl.sv | 114 +++++++++++
 tb/tb_sync_fifo_lvl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_lvl_if.sv
// sync_fifo_lvl_if: write/read handshake and occupancy status bundle for
// sync_fifo_lvl.
//   wr, w_data      write request and data (producer -> FIFO)
//   rd              read request, pops the head (consumer -> FIFO)
//   r_data          head entry, first-word fall-through (FIFO -> consumer)
//   empty, full     occupancy extremes, registered
//   almost_empty    count <= AE_LEVEL, registered
//   almost_full     count >= AF_LEVEL, registered
//   count           occupancy 0..DEPTH, registered
// Modports: master = the user side, slave = the FIFO.
interface sync_fifo_lvl_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) ();
    logic              wr;
    logic [DWIDTH-1:0] w_data;
    logic              rd;
    logic [DWIDTH-1:0] r_data;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [AWIDTH:0]   count;

    modport master (
        output wr, w_data, rd,
        input  r_data, empty, full, almost_empty, almost_full, count
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, empty, full, almost_empty, almost_full, count
    );
endinterface

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow flags and synchronous flush.
//   clk        rising-edge clock
//   reset      synchronous active-high reset (clears errors too)
//   flush      synchronous discard of stored entries (errors retained)
//   clear_err  clears overflow/underflow (a same-cycle error event wins)
//   bus        sync_fifo_lvl_if.slave: wr/w_data/rd in, r_data and status out
//   overflow   sticky: write attempted while full
//   underflow  sticky: read attempted while empty
module sync_fifo_lvl #(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 4,
    parameter int AF_LEVEL = 2**AWIDTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            clear_err,
    sync_fifo_lvl_if.slave  bus,
    output logic            overflow,
    output logic            underflow
);
    localparam int DEPTH = 2**AWIDTH;

    localparam logic [AWIDTH:0]   DEPTH_C = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0]   AF_C    = (AWIDTH+1)'(AF_LEVEL);
    localparam logic [AWIDTH:0]   AE_C    = (AWIDTH+1)'(AE_LEVEL);
    localparam logic [AWIDTH:0]   CNT_ONE = (AWIDTH+1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   count_q;
    logic [AWIDTH:0]   count_next;
    logic              empty_q;
    logic              full_q;
    logic              ae_q;
    logic              af_q;
    logic              w_acc;
    logic              r_acc;
    logic              ovf_set;
    logic              unf_set;

    // Acceptance uses the registered flags, so a write into an empty FIFO
    // never lets the same-cycle read run the read pointer past the write.
    always_comb begin
        w_acc      = bus.wr & ~full_q;
        r_acc      = bus.rd & ~empty_q;
        ovf_set    = bus.wr & full_q & ~flush;
        unf_set    = bus.rd & empty_q & ~flush;
        count_next = count_q;
        if (w_acc && !r_acc) begin
            count_next = count_q + CNT_ONE;
        end else if (r_acc && !w_acc) begin
            count_next = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ae_q      <= 1'b1;
            af_q      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                // Legal thresholds make count 0 always almost_empty and
                // never almost_full.
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
                empty_q <= 1'b1;
                full_q  <= 1'b0;
                ae_q    <= 1'b1;
                af_q    <= 1'b0;
            end else begin
                if (w_acc) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (r_acc) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                count_q <= count_next;
                empty_q <= (count_next == '0);
                full_q  <= (count_next == DEPTH_C);
                ae_q    <= (count_next <= AE_C);
                af_q    <= (count_next >= AF_C);
            end
            overflow  <= ovf_set | (overflow  & ~clear_err);
            underflow <= unf_set | (underflow & ~clear_err);
        end
    end

    // Storage is not reset or flushed; only the pointers are.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_acc) begin
            mem[wr_ptr] <= bus.w_data;
        end
    end

    assign bus.r_data       = mem[rd_ptr];
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb_sync_fifo_lvl: self-checking bench for sync_fifo_lvl with AWIDTH=2,
// AF_LEVEL=3, AE_LEVEL=1. A reference queue holds the words the FIFO must
// return; each scenario task checks status and head data inline.
module tb_sync_fifo_lvl;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int AFL   = 3;
    localparam int AEL   = 1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic clear_err;
    logic overflow;
    logic underflow;

    sync_fifo_lvl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    sync_fifo_lvl #(
        .DWIDTH   (DW),
        .AWIDTH   (AW),
        .AF_LEVEL (AFL),
        .AE_LEVEL (AEL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .clear_err (clear_err),
        .bus       (bus),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int        pass_cnt = 0;
    int        total_cnt = 0;
    int        m_count = 0;
    bit        m_ovf = 1'b0;
    bit        m_unf = 1'b0;
    logic [7:0] sb[$];

    // Drive one cycle of stimulus, advance the reference model at the edge,
    // then release the inputs 1 time unit after the edge.
    task automatic tick(input bit w, input logic [7:0] d, input bit r,
                        input bit f, input bit c, input bit rst);
        bit wa;
        bit ra;
        bus.wr     = w;
        bus.w_data = d;
        bus.rd     = r;
        flush      = f;
        clear_err  = c;
        reset      = rst;
        @(posedge clk);
        if (rst) begin
            m_count = 0;
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (f) begin
            m_count = 0;
            sb.delete();
            m_ovf = m_ovf & ~c;
            m_unf = m_unf & ~c;
        end else begin
            wa = w && (m_count < DEPTH);
            ra = r && (m_count > 0);
            m_ovf = (w && m_count == DEPTH) || (m_ovf && !c);
            m_unf = (r && m_count == 0) || (m_unf && !c);
            if (ra) void'(sb.pop_front());
            if (wa) sb.push_back(d);
            m_count = m_count + int'(wa) - int'(ra);
        end
        #1;
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;
        flush     = 1'b0;
        clear_err = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        tick(0, 8'h00, 0, 0, 0, 1);
        total_cnt++; if (bus.count !== 3'd0) $display("FAIL reset_count got %0d exp 0", bus.count); else pass_cnt++;
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", bus.empty); else pass_cnt++;
        total_cnt++; if (bus.full !== 1'b0) $display("FAIL reset_full got %b exp 0", bus.full); else pass_cnt++;
        total_cnt++; if (bus.almost_empty !== 1'b1) $display("FAIL reset_ae got %b exp 1", bus.almost_empty); else pass_cnt++;
        total_cnt++; if (bus.almost_full !== 1'b0) $display("FAIL reset_af got %b exp 0", bus.almost_full); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow); else pass_cnt++;
        total_cnt++; if (underflow !== 1'b0) $display("FAIL reset_unf got %b exp 0", underflow); else pass_cnt++;
    endtask

    task automatic test_fill();
        logic [7:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            tick(1, pat[i], 0, 0, 0, 0);
            total_cnt++; if (bus.count !== 3'(i + 1)) $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.count, i + 1); else pass_cnt++;
            total_cnt++; if (bus.almost_empty !== ((i + 1) <= AEL)) $display("FAIL fill_ae[%0d] got %b exp %b", i, bus.almost_empty, (i + 1) <= AEL); else pass_cnt++;
            total_cnt++; if (bus.almost_full !== ((i + 1) >= AFL)) $display("FAIL fill_af[%0d] got %b exp %b", i, bus.almost_full, (i + 1) >= AFL); else pass_cnt++;
            total_cnt++; if (bus.full !== ((i + 1) == DEPTH)) $display("FAIL fill_full[%0d] got %b exp %b", i, bus.full, (i + 1) == DEPTH); else pass_cnt++;
            total_cnt++; if (bus.empty !== 1'b0) $display("FAIL fill_empty[%0d] got %b exp 0", i, bus.empty); else pass_cnt++;
            total_cnt++; if (bus.r_data !== 8'h11) $display("FAIL fill_head[%0d] got %h exp 11", i, bus.r_data); else pass_cnt++;
        end
    endtask

    task automatic test_overflow_drain();
        logic [7:0] exp;
        tick(1, 8'h55, 0, 0, 0, 0);
        total_cnt++; if (bus.count !== 3'd4) $display("FAIL ovf_count got %0d exp 4", bus.count); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp = sb[0];
            total_cnt++; if (bus.r_data !== exp) $display("FAIL drain_data[%0d] got %h exp %h", i, bus.r_data, exp); else pass_cnt++;
            tick(0, 8'h00, 1, 0, 0, 0);
        end
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", bus.empty); else pass_cnt++;
        total_cnt++; if (bus.count !== 3'd0) $display("FAIL drain_count got %0d exp 0", bus.count); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else pass_cnt++;
    endtask

    task automatic test_underflow_clear();
        tick(0, 8'h00, 1, 0, 0, 0);
        total_cnt++; if (underflow !== 1'b1) $display("FAIL unf_flag got %b exp 1", underflow); else pass_cnt++;
        total_cnt++; if (bus.count !== 3'd0) $display("FAIL unf_count got %0d exp 0", bus.count); else pass_cnt++;
        tick(0, 8'h00, 0, 0, 1, 0);
        total_cnt++; if (underflow !== 1'b0) $display("FAIL unf_clear got %b exp 0", underflow); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else pass_cnt++;
        tick(0, 8'h00, 1, 0, 1, 0);
        total_cnt++; if (underflow !== 1'b1) $display("FAIL unf_set_wins got %b exp 1", underflow); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        tick(1, 8'hA5, 1, 0, 0, 0);
        total_cnt++; if (bus.count !== 3'd1) $display("FAIL empty_rw_count got %0d exp 1", bus.count); else pass_cnt++;
        total_cnt++; if (bus.r_data !== 8'hA5) $display("FAIL empty_rw_data got %h exp a5", bus.r_data); else pass_cnt++;
        total_cnt++; if (underflow !== 1'b1) $display("FAIL empty_rw_unf got %b exp 1", underflow); else pass_cnt++;
        tick(0, 8'h00, 0, 0, 1, 0);
        tick(1, 8'hB1, 0, 0, 0, 0);
        tick(1, 8'hB2, 0, 0, 0, 0);
        tick(1, 8'hB3, 0, 0, 0, 0);
        total_cnt++; if (bus.full !== 1'b1) $display("FAIL full_before_rw got %b exp 1", bus.full); else pass_cnt++;
        tick(1, 8'hC0, 1, 0, 0, 0);
        total_cnt++; if (bus.count !== 3'd3) $display("FAIL full_rw_count got %0d exp 3", bus.count); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL full_rw_ovf got %b exp 1", overflow); else pass_cnt++;
        total_cnt++; if (bus.r_data !== 8'hB1) $display("FAIL full_rw_head got %h exp b1", bus.r_data); else pass_cnt++;
        while (sb.size() > 0) begin
            exp = sb[0];
            total_cnt++; if (bus.r_data !== exp) $display("FAIL simul_drain got %h exp %h", bus.r_data, exp); else pass_cnt++;
            tick(0, 8'h00, 1, 0, 0, 0);
        end
        tick(0, 8'h00, 0, 0, 1, 0);
    endtask

    task automatic test_wrap_throughput();
        logic [7:0] exp;
        tick(1, 8'h00, 0, 0, 0, 0);
        tick(1, 8'h01, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            exp = sb[0];
            total_cnt++; if (bus.r_data !== exp) $display("FAIL wrap_data[%0d] got %h exp %h", i, bus.r_data, exp); else pass_cnt++;
            tick(1, 8'(i + 2), 1, 0, 0, 0);
            total_cnt++; if (bus.count !== 3'd2) $display("FAIL wrap_count[%0d] got %0d exp 2", i, bus.count); else pass_cnt++;
        end
        while (sb.size() > 0) begin
            exp = sb[0];
            total_cnt++; if (bus.r_data !== exp) $display("FAIL wrap_tail got %h exp %h", bus.r_data, exp); else pass_cnt++;
            tick(0, 8'h00, 1, 0, 0, 0);
        end
        total_cnt++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL wrap_errs got %b%b exp 00", overflow, underflow); else pass_cnt++;
    endtask

    task automatic test_flush_reset();
        tick(0, 8'h00, 1, 0, 0, 0);
        tick(1, 8'h61, 0, 0, 0, 0);
        tick(1, 8'h62, 0, 0, 0, 0);
        tick(1, 8'h63, 0, 0, 0, 0);
        total_cnt++; if (bus.count !== 3'd3) $display("FAIL pre_flush_count got %0d exp 3", bus.count); else pass_cnt++;
        tick(1, 8'h64, 0, 1, 0, 0);
        total_cnt++; if (bus.count !== 3'd0) $display("FAIL flush_count got %0d exp 0", bus.count); else pass_cnt++;
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL flush_empty got %b exp 1", bus.empty); else pass_cnt++;
        total_cnt++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) $display("FAIL flush_thresh got %b%b exp 10", bus.almost_empty, bus.almost_full); else pass_cnt++;
        total_cnt++; if (underflow !== 1'b1) $display("FAIL flush_unf_kept got %b exp 1", underflow); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL flush_no_ovf got %b exp 0", overflow); else pass_cnt++;
        tick(1, 8'h77, 0, 0, 0, 0);
        total_cnt++; if (bus.r_data !== 8'h77) $display("FAIL post_flush_head got %h exp 77", bus.r_data); else pass_cnt++;
        total_cnt++; if (bus.count !== 3'(m_count)) $display("FAIL post_flush_count got %0d exp %0d", bus.count, m_count); else pass_cnt++;
        tick(1, 8'h78, 0, 0, 0, 0);
        tick(1, 8'h79, 0, 0, 0, 0);
        tick(1, 8'h7A, 0, 0, 0, 0);
        tick(1, 8'h7B, 0, 0, 0, 0);
        total_cnt++; if (overflow !== 1'b1) $display("FAIL pre_reset_ovf got %b exp 1", overflow); else pass_cnt++;
        tick(0, 8'h00, 0, 0, 0, 1);
        total_cnt++; if (bus.count !== 3'd0) $display("FAIL rst_count got %0d exp 0", bus.count); else pass_cnt++;
        total_cnt++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) $display("FAIL rst_empty_full got %b%b exp 10", bus.empty, bus.full); else pass_cnt++;
        total_cnt++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) $display("FAIL rst_thresh got %b%b exp 10", bus.almost_empty, bus.almost_full); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL rst_errs got %b%b exp 00", overflow, underflow); else pass_cnt++;
        total_cnt++; if (m_count != 0 || m_ovf || m_unf) $display("FAIL model_rst got %0d%b%b exp 000", m_count, m_ovf, m_unf); else pass_cnt++;
    endtask

    initial begin
        bus.wr     = 1'b0;
        bus.w_data = '0;
        bus.rd     = 1'b0;
        flush      = 1'b0;
        clear_err  = 1'b0;
        reset      = 1'b1;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow_clear();
        test_simultaneous();
        test_wrap_throughput();
        test_flush_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
